// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 16;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_idx_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin grant with last_grant history
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     req0,
    input  logic     req1,
    output logic     grant_valid,
    output req_idx_t grant_idx
);

    req_idx_t last_grant;

    // On a tie the requester that did not win last time goes first
    always_comb begin
        grant_valid = req0 || req1;
        grant_idx   = REQ_0;
        if (req0 && req1) begin
            grant_idx = (last_grant == REQ_0) ? REQ_1 : REQ_0;
        end else if (req1) begin
            grant_idx = REQ_1;
        end
    end

    // History starts at requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= REQ_1;
        end else if (grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two requesters sharing one single-port RAM; MEM_ARB_PERF_CNT_EN adds grant/conflict counters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  grant0_cnt,
    output logic [CNT_W-1:0]  grant1_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    logic     act0, act1;
    logic     gnt_valid;
    req_idx_t gnt_idx;
    logic     grant0, grant1;
    logic     rd_pending;
    req_idx_t rd_owner;

    assign act0 = m0_read || m0_write;
    assign act1 = m1_read || m1_write;

    mem_arb_rr u_rr (
        .clk         (clk),
        .reset       (reset),
        .req0        (act0),
        .req1        (act1),
        .grant_valid (gnt_valid),
        .grant_idx   (gnt_idx)
    );

    // Nothing is granted while reset is held, so the RAM port stays quiet
    assign grant0 = gnt_valid && (gnt_idx == REQ_0) && !reset;
    assign grant1 = gnt_valid && (gnt_idx == REQ_1) && !reset;

    assign m0_waitrequest = reset || (act0 && !grant0);
    assign m1_waitrequest = reset || (act1 && !grant1);

    // Write wins when a requester raises read and write together
    assign mem_chipselect = grant0 || grant1;
    assign mem_write      = grant1 ? m1_write : (grant0 ? m0_write : 1'b0);
    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign mem_clken      = 1'b1;

    // One-deep pipeline remembers who owns the RAM output next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= REQ_0;
        end else begin
            rd_pending <= mem_chipselect && !mem_write;
            if (mem_chipselect) begin
                rd_owner <= grant1 ? REQ_1 : REQ_0;
            end
        end
    end

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pending && (rd_owner == REQ_0);
    assign m1_readdatavalid = rd_pending && (rd_owner == REQ_1);

`ifdef MEM_ARB_PERF_CNT_EN
    // Saturating usage counters for grants and contended cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant0_cnt   <= '0;
            grant1_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant0) grant0_cnt <= sat_inc(grant0_cnt);
            if (grant1) grant1_cnt <= sat_inc(grant1_cnt);
            if (act0 && act1) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural RAM
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        owner;
        logic [15:0] data;
        logic [31:0] cyc;
    } rd_ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] m0_address, m1_address;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [10:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [15:0] mem_readdata = 16'h0000;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] grant0_cnt, grant1_cnt, conflict_cnt;
`endif

    int compared = 0;
    int failed   = 0;
    logic [31:0] cyc = 0;
    logic [31:0] s_cyc;
    logic        s_wait0, s_wait1, s_cs, s_wr, s_clken;
    logic [10:0] s_addr;
    logic [15:0] s_wdata;
    logic [1:0]  s_be;
    rd_ev_t      exp_q[$];
    rd_ev_t      obs_q[$];

    logic [15:0] ram [0:2047];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .grant0_cnt       (grant0_cnt),
        .grant1_cnt       (grant1_cnt),
        .conflict_cnt     (conflict_cnt)
`endif
    );

    // Synchronous RAM: q reflects the address clocked one cycle earlier
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic idle_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_byteenable = 2'b11; m1_byteenable = 2'b11;
    endtask

    task automatic exp_push(input logic owner, input logic [15:0] data);
        rd_ev_t e;
        e.owner = owner; e.data = data; e.cyc = s_cyc + 1;
        exp_q.push_back(e);
    endtask

    // Advance one clock: snapshot outputs mid-cycle and log any read strobes
    task automatic cycle();
        rd_ev_t o;
        @(negedge clk);
        s_cyc = cyc;
        s_wait0 = m0_waitrequest; s_wait1 = m1_waitrequest;
        s_cs = mem_chipselect; s_wr = mem_write; s_clken = mem_clken;
        s_addr = mem_address; s_wdata = mem_writedata; s_be = mem_byteenable;
        if (m0_readdatavalid) begin
            o.owner = 1'b0; o.data = m0_readdata; o.cyc = cyc; obs_q.push_back(o);
        end
        if (m1_readdatavalid) begin
            o.owner = 1'b1; o.data = m1_readdata; o.cyc = cyc; obs_q.push_back(o);
        end
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_read = 1'b1; m1_write = 1'b1;
        cycle();
        compared++; if (s_wait0 !== 1'b1) begin failed++; $display("FAIL rst_wait0: got %b required 1", s_wait0); end
        compared++; if (s_wait1 !== 1'b1) begin failed++; $display("FAIL rst_wait1: got %b required 1", s_wait1); end
        compared++; if (s_cs !== 1'b0) begin failed++; $display("FAIL rst_cs: got %b required 0", s_cs); end
        compared++; if (s_wr !== 1'b0) begin failed++; $display("FAIL rst_write: got %b required 0", s_wr); end
        reset = 1'b0;
        idle_inputs();
        cycle();
        compared++; if ({s_wait1, s_wait0} !== 2'b00) begin failed++; $display("FAIL idle_wait: got %b required 00", {s_wait1, s_wait0}); end
        compared++; if ({s_cs, s_wr} !== 2'b00) begin failed++; $display("FAIL idle_cs_wr: got %b required 00", {s_cs, s_wr}); end
        compared++; if (s_clken !== 1'b1) begin failed++; $display("FAIL clken: got %b required 1", s_clken); end
`ifdef MEM_ARB_PERF_CNT_EN
        compared++; if (conflict_cnt !== 16'd0) begin failed++; $display("FAIL rst_conflict_cnt: got %0d required 0", conflict_cnt); end
`endif
    endtask

    task automatic test_write_read();
        m0_write = 1'b1; m0_address = 11'h005; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
        cycle();
        compared++; if (s_wait0 !== 1'b0) begin failed++; $display("FAIL wr_wait0: got %b required 0", s_wait0); end
        compared++; if ({s_cs, s_wr} !== 2'b11) begin failed++; $display("FAIL wr_cs_wr: got %b required 11", {s_cs, s_wr}); end
        compared++; if (s_addr !== 11'h005) begin failed++; $display("FAIL wr_addr: got %h required 005", s_addr); end
        compared++; if (s_wdata !== 16'hBEEF) begin failed++; $display("FAIL wr_data: got %h required beef", s_wdata); end
        m0_write = 1'b0; m0_read = 1'b1;
        cycle();
        compared++; if ({s_wait0, s_wr} !== 2'b00) begin failed++; $display("FAIL rd_wait_wr: got %b required 00", {s_wait0, s_wr}); end
        exp_push(1'b0, 16'hBEEF);
        idle_inputs();
        repeat (2) cycle();
    endtask

    task automatic test_simul_reads();
        m0_write = 1'b1; m0_address = 11'h001; m0_writedata = 16'hA001;
        cycle();
        m0_write = 1'b0;
        m1_write = 1'b1; m1_address = 11'h002; m1_writedata = 16'hB002;
        cycle();
        idle_inputs();
        cycle();
        reset_pulse();
        m0_read = 1'b1; m0_address = 11'h001;
        m1_read = 1'b1; m1_address = 11'h002;
        cycle();
        compared++; if ({s_wait1, s_wait0} !== 2'b10) begin failed++; $display("FAIL tie_first: got wait1/0=%b required 10", {s_wait1, s_wait0}); end
        compared++; if (s_addr !== 11'h001) begin failed++; $display("FAIL tie_addr0: got %h required 001", s_addr); end
        exp_push(1'b0, 16'hA001);
        m0_read = 1'b0;
        cycle();
        compared++; if (s_wait1 !== 1'b0) begin failed++; $display("FAIL tie_second: got wait1=%b required 0", s_wait1); end
        compared++; if (s_addr !== 11'h002) begin failed++; $display("FAIL tie_addr1: got %h required 002", s_addr); end
        exp_push(1'b1, 16'hB002);
        idle_inputs();
        repeat (2) cycle();
    endtask

    task automatic test_round_robin();
        int n0 = 0;
        int n1 = 0;
        logic win;
        reset_pulse();
        m0_read = 1'b1; m0_address = 11'h001;
        m1_read = 1'b1; m1_address = 11'h002;
        for (int i = 0; i < 8; i++) begin
            cycle();
            win = i[0];
            compared++; if ({s_wait1, s_wait0} !== {!win, win}) begin failed++; $display("FAIL rr_cycle%0d: got wait1/0=%b required %b", i, {s_wait1, s_wait0}, {!win, win}); end
            if (!s_wait0) n0++;
            if (!s_wait1) n1++;
            exp_push(win, win ? 16'hB002 : 16'hA001);
        end
        idle_inputs();
        compared++; if (n0 !== 4 || n1 !== 4) begin failed++; $display("FAIL rr_share: got %0d/%0d required 4/4", n0, n1); end
`ifdef MEM_ARB_PERF_CNT_EN
        compared++; if (conflict_cnt !== 16'd8) begin failed++; $display("FAIL conflict_cnt: got %0d required 8", conflict_cnt); end
        compared++; if (grant0_cnt !== 16'd4 || grant1_cnt !== 16'd4) begin failed++; $display("FAIL grant_cnt: got %0d/%0d required 4/4", grant0_cnt, grant1_cnt); end
`endif
        repeat (2) cycle();
    endtask

    task automatic test_reset_mid_read();
        m0_read = 1'b1; m0_address = 11'h005;
        cycle();
        compared++; if (s_wait0 !== 1'b0) begin failed++; $display("FAIL mid_accept: got wait0=%b required 0", s_wait0); end
        idle_inputs();
        reset_pulse();
        cycle();
        m0_read = 1'b1; m0_address = 11'h001;
        m1_read = 1'b1; m1_address = 11'h002;
        cycle();
        compared++; if ({s_wait1, s_wait0} !== 2'b10) begin failed++; $display("FAIL mid_last_grant: got wait1/0=%b required 10", {s_wait1, s_wait0}); end
        exp_push(1'b0, 16'hA001);
        m0_read = 1'b0;
        cycle();
        exp_push(1'b1, 16'hB002);
        idle_inputs();
        repeat (2) cycle();
    endtask

    task automatic test_byte_enable();
        logic [15:0] mask;
        m1_write = 1'b1; m1_address = 11'h7FF; m1_writedata = 16'h3456; m1_byteenable = 2'b11;
        cycle();
        compared++; if ({s_wait1, s_wr, s_addr} !== {1'b0, 1'b1, 11'h7FF}) begin failed++; $display("FAIL be_full_wr: got wait/wr/addr=%b/%b/%h required 0/1/7ff", s_wait1, s_wr, s_addr); end
        m1_writedata = 16'h12AB; m1_byteenable = 2'b01;
        cycle();
        compared++; if (s_be !== 2'b01) begin failed++; $display("FAIL be_lanes: got %b required 01", s_be); end
        m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 2'b11;
        cycle();
        mask = 16'h00FF;
        exp_push(1'b1, (16'h3456 & ~mask) | (16'h12AB & mask));
        idle_inputs();
        repeat (2) cycle();
    endtask

    task automatic test_read_scoreboard();
        rd_ev_t e, o;
        repeat (3) cycle();
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            compared++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front();
                failed++;
                $display("FAIL rd_extra: got owner=%0d data=%h cyc=%0d required none", o.owner, o.data, o.cyc);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front();
                failed++;
                $display("FAIL rd_missing: got none required owner=%0d data=%h cyc=%0d", e.owner, e.data, e.cyc);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    failed++;
                    $display("FAIL rd_event: got owner=%0d data=%h cyc=%0d required owner=%0d data=%h cyc=%0d",
                             o.owner, o.data, o.cyc, e.owner, e.data, e.cyc);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        m0_address = '0; m1_address = '0;
        m0_writedata = '0; m1_writedata = '0;
        test_reset();
        test_write_read();
        test_simul_reads();
        test_round_robin();
        test_reset_mid_read();
        test_byte_enable();
        test_read_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, word address width of the shared RAM (2048 x 16).
REQ-002 Parameter DATA_W, default 16, data width; BE_W = DATA_W/8 (default 2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mN_address  input  ADDR_W  requester N address, N in {0,1}.
REQ-006 mN_byteenable  input  BE_W  requester N byte lanes.
REQ-007 mN_read / mN_write  input  1 each  requester N read/write request.
REQ-008 mN_writedata  input  DATA_W  requester N write data.
REQ-009 mN_waitrequest  output  1  high = request not accepted this cycle.
REQ-010 mN_readdata  output  DATA_W  read data to requester N.
REQ-011 mN_readdatavalid  output  1  one-cycle strobe qualifying mN_readdata.
REQ-012 mem_address / mem_byteenable / mem_writedata  output  ADDR_W / BE_W / DATA_W  to RAM port.
REQ-013 mem_chipselect / mem_write / mem_clken  output  1 each  to RAM port.
REQ-014 mem_readdata  input  DATA_W  RAM q, valid one cycle after address is clocked.

Function
REQ-015 Requester N is active when mN_read or mN_write is high; if both are high, the cycle SHALL be treated as a write.
REQ-016 At most one requester SHALL be granted per cycle; grant is combinational from active requests and the last_grant register.
REQ-017 Single active requester SHALL be granted immediately (zero-wait accept).
REQ-018 Both active: the requester not equal to last_grant SHALL be granted (round-robin); last_grant updates on every grant.
REQ-019 Granted requester's waitrequest SHALL be low in the grant cycle; the loser's waitrequest SHALL be high and it must hold its request stable.
REQ-020 No active requester: both waitrequest SHALL be low (idle), mem_chipselect low, mem_write low.
REQ-021 On grant, mem_address/byteenable/writedata SHALL mux from the granted requester; mem_chipselect high; mem_write = granted write.
REQ-022 mem_clken SHALL be constant 1 out of reset.
REQ-023 Read accepted at cycle T: mN_readdatavalid SHALL pulse at T+1 for owner only, mN_readdata = mem_readdata; latency fixed at 1.
REQ-024 Back-to-back reads (any owner order) SHALL sustain one read per cycle; rd_pending/rd_owner pipeline register tracks the T+1 owner.
REQ-025 Writes SHALL produce no readdatavalid.
REQ-026 mN_readdata SHALL be driven with mem_readdata regardless of valid; only valid is qualified.

Reset
REQ-027 On reset: last_grant = 1 (requester 0 wins first tie), rd_pending = 0, rd_owner = 0, both readdatavalid = 0.
REQ-028 Reset mid-read SHALL discard the pending readdatavalid; no strobe after reset release.
REQ-029 During reset, mem_chipselect and mem_write SHALL be 0 and both waitrequest SHALL be 1.

Configuration
REQ-030 Macro MEM_ARB_PERF_CNT_EN defined: add outputs grant0_cnt, grant1_cnt, conflict_cnt (each 16-bit, saturating at 0xFFFF, cleared by reset); grantN_cnt increments per grant to N, conflict_cnt per cycle with both active.
REQ-031 Macro undefined: those outputs and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package mem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, requester-index typedef, and counter width constant (16).
REQ-033 One sub-module, mem_arb_rr, SHALL implement the 2-way round-robin grant and last_grant register; datapath mux and read pipeline stay in the top.

Verification
REQ-034 m0 write addr 0x005 data 0xBEEF be 2'b11 alone -> m0_waitrequest 0 same cycle, mem_write 1, mem_address 0x005.
REQ-035 m0 read 0x005 next cycle -> m0_readdatavalid at T+1 with 0xBEEF; m1_readdatavalid stays 0.
REQ-036 m0 and m1 read 0x001/0x002 simultaneously after reset -> m0 granted first, m1 next cycle; valids at T+1 (m0) and T+2 (m1).
REQ-037 Both requesters continuously active for 8 cycles -> grants alternate 0,1,0,1...; each gets 4; with MEM_ARB_PERF_CNT_EN, conflict_cnt = 8.
REQ-038 Reset asserted in the cycle after a read accept -> no readdatavalid after release; last_grant = 1.
REQ-039 m1 write be 2'b01 data 0x12AB to 0x7FF, then read -> readdata low byte 0xAB, high byte unchanged from prior contents.
